// File: rtl/mem_arbiter_if.sv
// Signal bundle joining the two requester ports, the arbiter and the shared mem_system.
// master = requesters plus mem_system (environment side), slave = the arbiter.
interface mem_arbiter_if;
   localparam int unsigned DW = 16;

   logic [DW-1:0] Addr0, DataIn0, Addr1, DataIn1;
   logic          Rd0, Wr0, Rd1, Wr1;
   logic [DW-1:0] DataOut0, DataOut1;
   logic          Done0, Done1, CacheHit0, CacheHit1, Stall0, Stall1;
   logic [DW-1:0] mem_Addr, mem_DataIn, mem_DataOut;
   logic          mem_Rd, mem_Wr, mem_Done, mem_Stall, mem_CacheHit;
   logic          err_illegal, err_timeout;

   modport master (
      output Addr0, DataIn0, Rd0, Wr0, Addr1, DataIn1, Rd1, Wr1,
      output mem_DataOut, mem_Done, mem_Stall, mem_CacheHit,
      input  DataOut0, DataOut1, Done0, Done1, CacheHit0, CacheHit1, Stall0, Stall1,
      input  mem_Addr, mem_DataIn, mem_Rd, mem_Wr, err_illegal, err_timeout
   );

   modport slave (
      input  Addr0, DataIn0, Rd0, Wr0, Addr1, DataIn1, Rd1, Wr1,
      input  mem_DataOut, mem_Done, mem_Stall, mem_CacheHit,
      output DataOut0, DataOut1, Done0, Done1, CacheHit0, CacheHit1, Stall0, Stall1,
      output mem_Addr, mem_DataIn, mem_Rd, mem_Wr, err_illegal, err_timeout
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a shared mem_system: alternating tie-break, registered
// request to memory, combinational completion back to the granted port, wait timeout.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 31
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 6;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_t;

   state_t        state, state_nx;
   logic          last_grant, last_grant_nx;
   logic [CW-1:0] wait_cnt, wait_cnt_nx, wait_inc;
   logic [DW-1:0] addr_q, addr_nx, wdata_q, wdata_nx;
   logic          rd_q, rd_nx, wr_q, wr_nx;
   logic          err_ill_q, err_ill_nx, err_to_q, err_to_nx;
   logic          req0, req1, grant1, sel_rd, sel_wr;
   logic          done0, done1;

   assign req0     = bus.Rd0 | bus.Wr0;
   assign req1     = bus.Rd1 | bus.Wr1;
   // On a tie the port that did not win last time goes next; otherwise the sole requester.
   assign grant1   = (req0 & req1) ? ~last_grant : req1;
   assign sel_rd   = grant1 ? bus.Rd1 : bus.Rd0;
   assign sel_wr   = grant1 ? bus.Wr1 : bus.Wr0;
   assign wait_inc = wait_cnt + CW'(1);

   // Next-state and next request registers
   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      wait_cnt_nx   = wait_cnt;
      addr_nx       = addr_q;
      wdata_nx      = wdata_q;
      rd_nx         = rd_q;
      wr_nx         = wr_q;
      err_ill_nx    = err_ill_q;
      err_to_nx     = err_to_q;
      unique case (state)
         IDLE: begin
            if (!bus.mem_Stall && (req0 | req1)) begin
               state_nx      = grant1 ? BUSY1 : BUSY0;
               last_grant_nx = grant1;
               wait_cnt_nx   = '0;
               addr_nx       = grant1 ? bus.Addr1 : bus.Addr0;
               wdata_nx      = grant1 ? bus.DataIn1 : bus.DataIn0;
               // A simultaneous read+write is flagged and downgraded to a plain write.
               rd_nx         = sel_rd & ~sel_wr;
               wr_nx         = sel_wr;
               err_ill_nx    = err_ill_q | (sel_rd & sel_wr);
            end
         end
         BUSY0, BUSY1: begin
            if (bus.mem_Done) begin
               state_nx = IDLE;
               rd_nx    = 1'b0;
               wr_nx    = 1'b0;
            end else begin
               wait_cnt_nx = wait_inc;
               if (wait_inc == CW'(TIMEOUT)) begin
                  state_nx  = IDLE;
                  rd_nx     = 1'b0;
                  wr_nx     = 1'b0;
                  err_to_nx = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wait_cnt   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         err_ill_q  <= 1'b0;
         err_to_q   <= 1'b0;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
         wait_cnt   <= wait_cnt_nx;
         addr_q     <= addr_nx;
         wdata_q    <= wdata_nx;
         rd_q       <= rd_nx;
         wr_q       <= wr_nx;
         err_ill_q  <= err_ill_nx;
         err_to_q   <= err_to_nx;
      end
   end

   // Completion is passed through in the same cycle mem_Done arrives.
   assign done0 = (state == BUSY0) & bus.mem_Done;
   assign done1 = (state == BUSY1) & bus.mem_Done;

   assign bus.Done0       = done0;
   assign bus.Done1       = done1;
   assign bus.DataOut0    = done0 ? bus.mem_DataOut : '0;
   assign bus.DataOut1    = done1 ? bus.mem_DataOut : '0;
   assign bus.CacheHit0   = done0 & bus.mem_CacheHit;
   assign bus.CacheHit1   = done1 & bus.mem_CacheHit;
   assign bus.Stall0      = (state != IDLE) | bus.mem_Stall;
   assign bus.Stall1      = (state != IDLE) | bus.mem_Stall;
   assign bus.mem_Addr    = addr_q;
   assign bus.mem_DataIn  = wdata_q;
   assign bus.mem_Rd      = rd_q;
   assign bus.mem_Wr      = wr_q;
   assign bus.err_illegal = err_ill_q;
   assign bus.err_timeout = err_to_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random two-port traffic
// against a memory responder, checked by a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int unsigned TO = 31;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bus();
   mem_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed { logic [15:0] data; logic hit; } resp_t;
   typedef struct packed { logic [15:0] addr; logic [15:0] wdata; logic rd; logic wr; } grant_t;

   resp_t  q0[$], q1[$];
   grant_t gq[$];
   logic [15:0] model_mem [logic [15:0]];
   logic [15:0] store     [logic [15:0]];

   int errors = 0;
   int checks = 0;

   bit resp_en = 1'b1, stall_en = 1'b0, stall_force = 1'b0;
   int lat_fix = -1, lat_max = 4;
   int idle_req = 0, idle_ack = 0;

   // Abstract model of arbitration state
   bit m_busy = 1'b0, m_port = 1'b0, m_last = 1'b1, m_ill = 1'b0, m_to = 1'b0, prev_act = 1'b0;
   int m_wait = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem_default(input logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   // Requester: push expected response, hold request until Done, drop it the next cycle.
   task automatic issue(input bit p, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d);
      resp_t e;
      bit    seen = 1'b0;
      e.data = wr ? 16'h0000 : (model_mem.exists(a) ? model_mem[a] : mem_default(a));
      e.hit  = a[0];
      if (wr) model_mem[a] = d;
      if (p) begin
         q1.push_back(e);
         bus.Addr1 = a; bus.DataIn1 = d; bus.Rd1 = rd; bus.Wr1 = wr;
      end else begin
         q0.push_back(e);
         bus.Addr0 = a; bus.DataIn0 = d; bus.Rd0 = rd; bus.Wr0 = wr;
      end
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         seen = p ? bus.Done1 : bus.Done0;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL done_wait port%0d: got no Done expected Done within 300 cycles", p);
      end
      @(posedge clk); #1;
      if (p) begin bus.Rd1 = 1'b0; bus.Wr1 = 1'b0; end
      else   begin bus.Rd0 = 1'b0; bus.Wr0 = 1'b0; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // mem_system responder: random or fixed latency, reads from a backing store.
   initial begin : responder
      bit active;
      int lat;
      active = 1'b0; lat = 0;
      bus.mem_Done = 1'b0; bus.mem_DataOut = '0; bus.mem_CacheHit = 1'b0; bus.mem_Stall = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bus.mem_Done) begin
            bus.mem_Done = 1'b0; bus.mem_DataOut = '0; bus.mem_CacheHit = 1'b0; active = 1'b0;
         end else if (idle_req != idle_ack) begin
            idle_ack++;
            bus.mem_Done = 1'b1; bus.mem_DataOut = 16'hDEAD; bus.mem_CacheHit = 1'b1;
         end else if (bus.mem_Rd || bus.mem_Wr) begin
            if (!active) begin
               active = 1'b1;
               lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(lat_max, 0));
            end
            if (resp_en) begin
               if (lat == 0) begin
                  bus.mem_Done     = 1'b1;
                  bus.mem_CacheHit = bus.mem_Addr[0];
                  if (bus.mem_Wr) begin
                     store[bus.mem_Addr] = bus.mem_DataIn;
                     bus.mem_DataOut = 16'h0000;
                  end else begin
                     bus.mem_DataOut = store.exists(bus.mem_Addr) ? store[bus.mem_Addr]
                                                                  : mem_default(bus.mem_Addr);
                  end
               end else begin
                  lat--;
               end
            end
         end else begin
            active = 1'b0;
         end
         bus.mem_Stall = stall_force | (stall_en && ($urandom_range(3, 0) == 0));
      end
   end

   // Monitor + model: checks DUT outputs each cycle, then advances the model.
   initial begin : monitor
      grant_t g;
      resp_t  r;
      bit     r0, r1, p, act, ed0, ed1;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_busy = 1'b0; m_last = 1'b1; m_wait = 0; m_ill = 1'b0; m_to = 1'b0;
            prev_act = 1'b0;
            gq.delete();
         end else begin
            act = bus.mem_Rd | bus.mem_Wr;
            if (act && !prev_act) begin
               if (gq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL grant: got request addr %0h expected no grant", bus.mem_Addr);
               end else begin
                  g = gq.pop_front();
                  chk("grant", 64'({bus.mem_Addr, bus.mem_DataIn, bus.mem_Rd, bus.mem_Wr}),
                      64'({g.addr, g.wdata, g.rd, g.wr}));
               end
            end
            prev_act = act;

            chk("stall", 64'({bus.Stall0, bus.Stall1}), 64'({2{m_busy | bus.mem_Stall}}));
            chk("err_flags", 64'({bus.err_illegal, bus.err_timeout}), 64'({m_ill, m_to}));
            ed0 = m_busy && !m_port && bus.mem_Done;
            ed1 = m_busy &&  m_port && bus.mem_Done;
            chk("done", 64'({bus.Done0, bus.Done1}), 64'({ed0, ed1}));

            if (bus.Done0) begin
               if (q0.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL resp0: got Done0 expected no pending request");
               end else begin
                  r = q0.pop_front();
                  chk("resp0", 64'({bus.DataOut0, bus.CacheHit0}), 64'({r.data, r.hit}));
               end
            end else begin
               chk("idle_out0", 64'(bus.DataOut0), 64'(0));
               if (!(m_busy && !m_port)) chk("idle_hit0", 64'(bus.CacheHit0), 64'(0));
            end
            if (bus.Done1) begin
               if (q1.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL resp1: got Done1 expected no pending request");
               end else begin
                  r = q1.pop_front();
                  chk("resp1", 64'({bus.DataOut1, bus.CacheHit1}), 64'({r.data, r.hit}));
               end
            end else begin
               chk("idle_out1", 64'(bus.DataOut1), 64'(0));
               if (!(m_busy && m_port)) chk("idle_hit1", 64'(bus.CacheHit1), 64'(0));
            end

            r0 = bus.Rd0 | bus.Wr0;
            r1 = bus.Rd1 | bus.Wr1;
            if (m_busy) begin
               if (bus.mem_Done) m_busy = 1'b0;
               else begin
                  m_wait++;
                  if (m_wait >= int'(TO)) begin m_busy = 1'b0; m_to = 1'b1; end
               end
            end else if (!bus.mem_Stall && (r0 || r1)) begin
               p = (r0 && r1) ? !m_last : r1;
               m_busy = 1'b1; m_port = p; m_last = p; m_wait = 0;
               g.addr  = p ? bus.Addr1 : bus.Addr0;
               g.wdata = p ? bus.DataIn1 : bus.DataIn0;
               g.wr    = p ? bus.Wr1 : bus.Wr0;
               g.rd    = (p ? bus.Rd1 : bus.Rd0) & !g.wr;
               if ((p ? bus.Rd1 : bus.Rd0) && g.wr) m_ill = 1'b1;
               gq.push_back(g);
            end
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: got no finish expected finish before 500us");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      bus.Addr0 = '0; bus.DataIn0 = '0; bus.Rd0 = 1'b0; bus.Wr0 = 1'b0;
      bus.Addr1 = '0; bus.DataIn1 = '0; bus.Rd1 = 1'b0; bus.Wr1 = 1'b0;
      store[16'h1234] = 16'hBEEF;
      model_mem[16'h1234] = 16'hBEEF;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem", 64'({bus.mem_Rd, bus.mem_Wr, bus.mem_Addr, bus.mem_DataIn}), 64'(0));
      chk("rst_err", 64'({bus.err_illegal, bus.err_timeout}), 64'(0));
      rst = 1'b0;
      chk("rst_stall", 64'({bus.Stall0, bus.Stall1}), 64'(0));

      // Single read, done after 3 BUSY cycles, granted on the first edge after reset
      lat_fix = 3;
      issue(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000);

      // Simultaneous requests, repeated
      lat_fix = 1;
      for (int i = 0; i < 3; i++) begin
         fork
            issue(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000);
            issue(1'b1, 1'b0, 1'b1, 16'h0040, 16'h55AA + 16'(i));
         join
      end

      // Request held off by mem_Stall
      @(negedge clk); stall_force = 1'b1;
      @(posedge clk); #1;
      fork
         issue(1'b0, 1'b0, 1'b1, 16'h0200, 16'h1111);
         begin
            repeat (5) @(negedge clk);
            chk("stall_hold", 64'({bus.Stall0, bus.mem_Rd, bus.mem_Wr}), 64'(3'b100));
            stall_force = 1'b0;
         end
      join

      // mem_Done while idle must not produce Done
      idle_req++;
      repeat (3) begin @(posedge clk); #1; end

      // No response: timeout, then re-arbitration completes it
      lat_fix = -1;
      resp_en = 1'b0;
      fork
         issue(1'b0, 1'b1, 1'b0, 16'h0300, 16'h0000);
         begin repeat (45) @(negedge clk); resp_en = 1'b1; end
      join
      chk("timeout_flag", 64'(bus.err_timeout), 64'(1));
      do_reset();

      // Random traffic with random mem_Stall and latency
      stall_en = 1'b1;
      fork
         begin
            int gap0;
            bit w0;
            for (int i = 0; i < 40; i++) begin
               gap0 = int'($urandom_range(3, 0));
               repeat (gap0) begin @(posedge clk); #1; end
               w0 = 1'($urandom_range(1, 0));
               issue(1'b0, !w0, w0, 16'h0100 + 16'($urandom_range(7, 0)), 16'($urandom));
            end
         end
         begin
            int gap1;
            bit w1;
            for (int j = 0; j < 40; j++) begin
               gap1 = int'($urandom_range(3, 0));
               repeat (gap1) begin @(posedge clk); #1; end
               w1 = 1'($urandom_range(1, 0));
               issue(1'b1, !w1, w1, 16'h8100 + 16'($urandom_range(7, 0)), 16'($urandom));
            end
         end
      join
      stall_en = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      // Read+write together is flagged, issued as write, and the flag sticks
      issue(1'b1, 1'b1, 1'b1, 16'h0040, 16'hC3C3);
      repeat (5) begin @(posedge clk); #1; end
      chk("illegal_sticky", 64'(bus.err_illegal), 64'(1));

      // Reset in the middle of a port 1 transaction
      resp_en = 1'b0;
      bus.Addr1 = 16'h0500; bus.DataIn1 = 16'h0000; bus.Rd1 = 1'b1; bus.Wr1 = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk("busy1_pre_rst", 64'({bus.mem_Rd, bus.Stall1}), 64'(2'b11));
      rst = 1'b1;
      #1;
      chk("rst_async_mem", 64'({bus.mem_Rd, bus.mem_Wr, bus.mem_Addr, bus.mem_DataIn}), 64'(0));
      chk("rst_async_out", 64'({bus.Done1, bus.Stall1, bus.err_illegal, bus.err_timeout}), 64'(0));
      bus.Rd1 = 1'b0;
      resp_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      lat_fix = 2;
      issue(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000);
      repeat (4) begin @(posedge clk); #1; end

      chk("grant_q_empty", 64'(gq.size()), 64'(0));
      chk("resp_q_empty", 64'(q0.size() + q1.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 31, max cycles a granted request may wait for mem_Done before abort (range 4..63).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Addr0, DataIn0  input  16 each  port 0 (instruction fetch) address / write data.
REQ-005 Rd0, Wr0  input  1 each  port 0 read / write request; held by requester until Done0.
REQ-006 Addr1, DataIn1, Rd1, Wr1  input  16/16/1/1  port 1 (data) request, same rules as port 0.
REQ-007 DataOut0, DataOut1  output  16 each  read data returned to each port.
REQ-008 Done0, Done1, CacheHit0, CacheHit1  output  1 each  completion pulse and hit flag per port.
REQ-009 Stall0, Stall1  output  1 each  port must not present a new request while high.
REQ-010 mem_Addr, mem_DataIn  output  16 each  registered request to shared mem_system.
REQ-011 mem_Rd, mem_Wr  output  1 each  registered request strobes to mem_system.
REQ-012 mem_DataOut  input  16; mem_Done, mem_Stall, mem_CacheHit  input  1 each  mem_system responses.
REQ-013 err_illegal, err_timeout  output  1 each  sticky error flags.

Function
REQ-014 States: IDLE, BUSY0, BUSY1; "request on port N" = RdN | WrN.
REQ-015 IDLE: if mem_Stall==0 and at least one request, grant and enter BUSYN next cycle; else stay IDLE.
REQ-016 Tie (both ports requesting in IDLE): grant port != last_grant; last_grant updates to granted port on each grant.
REQ-017 On grant, register AddrN, DataInN, WrN, RdN into mem_Addr, mem_DataIn, mem_Wr, mem_Rd (visible first cycle of BUSYN).
REQ-018 RdN and WrN both high at grant: set err_illegal, issue as write only (mem_Wr=1, mem_Rd=0).
REQ-019 BUSYN: mem_Addr/mem_DataIn/mem_Rd/mem_Wr held constant; requester inputs ignored.
REQ-020 BUSYN with mem_Done=1: DoneN=1, DataOutN=mem_DataOut, CacheHitN=mem_CacheHit combinationally that cycle; next cycle IDLE with mem_Rd=mem_Wr=0.
REQ-021 Done, DataOut, CacheHit of the non-granted port = 0 at all times; DataOutN=0 when DoneN=0.
REQ-022 mem_Done while IDLE: ignored, no Done pulse.
REQ-023 Wait counter (6 bit) clears on grant, increments each BUSY cycle without mem_Done; reaching TIMEOUT: set err_timeout, drop mem_Rd/mem_Wr, return IDLE, no Done pulse; request remains pending and is re-arbitrated.
REQ-024 StallN = 1 when state != IDLE, or when mem_Stall==1; StallN = 0 in IDLE with mem_Stall==0.
REQ-025 Requester deasserts RdN/WrN in the cycle after DoneN; a request still high in the following IDLE cycle is a new request.
REQ-026 Minimum turnaround: request in IDLE cycle T -> mem_Rd/Wr high at T+1; mem_Done at M -> next grant visible no earlier than M+2.
REQ-027 err_illegal and err_timeout cleared only by reset.

Reset
REQ-028 rst high, asynchronously: state=IDLE, last_grant=1 (port 0 wins first tie), wait counter=0, mem_Addr=mem_DataIn=0, mem_Rd=mem_Wr=0, err flags=0.
REQ-029 Reset mid-request abandons the transaction; no Done pulse; outputs reach reset values without a clock edge.
REQ-030 First grant possible in the first clock edge after rst deasserts.

Verification
REQ-031 Rd0=1 Addr0=0x1234 only, mem_Done after 3 BUSY cycles with mem_DataOut=0xBEEF, mem_CacheHit=0 -> mem_Rd=1 mem_Addr=0x1234 in BUSY0, Done0=1 DataOut0=0xBEEF, Done1=0.
REQ-032 Rd0 and Wr1 (Addr1=0x0040, DataIn1=0x55AA) same IDLE cycle after reset -> port 0 served first, then port 1 with mem_Wr=1 mem_DataIn=0x55AA; repeated tie -> port 1 then port 0 alternation.
REQ-033 Request while mem_Stall=1 -> stays IDLE, Stall0=1, no mem_Rd/mem_Wr until mem_Stall=0.
REQ-034 Granted request, mem_Done never asserted, TIMEOUT=31 -> err_timeout=1 after 31 BUSY cycles, mem_Rd=0 next cycle, no Done, request re-granted.
REQ-035 Rd1=Wr1=1 -> err_illegal=1, mem_Wr=1, mem_Rd=0; stays 1 until rst.
REQ-036 rst asserted in BUSY1 before mem_Done -> immediately state IDLE, mem_Rd=mem_Wr=0, Done1 never pulses.
